riscv_retire_trace: RTL and testbench

//  Synthesizable retirement monitor attached to the riscv_core writeback outputs (pipe0/pipe1 of u_issue).

---
 rtl/riscv_retire_trace_pkg.sv | 32 +++
 rtl/riscv_retire_fifo.sv | 59 +++++
 rtl/riscv_retire_trace.sv | 157 +++++++++++++++
 tb/tb_riscv_retire_trace.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_retire_trace_pkg.sv
// Shared definitions for the retirement trace monitor: record layout, FSM states
// and the completion-trigger decode.
package riscv_retire_trace_pkg;

  localparam int REC_W = 102;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_CSRRW   = 3'b001;

  typedef logic [REC_W-1:0] rec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_csrrw(input logic [31:0] opc);
    return (opc[6:0] == OPC_SYSTEM) && (opc[14:12] == F3_CSRRW);
  endfunction

  // Record layout: {pipe_id, rd, pc, opc, result}
  function automatic rec_t pack_rec(input logic        pipe_id,
                                    input logic [4:0]  rd,
                                    input logic [31:0] pc,
                                    input logic [31:0] opc,
                                    input logic [31:0] result);
    return {pipe_id, rd, pc, opc, result};
  endfunction

endpackage

// File: rtl/riscv_retire_fifo.sv
// Two-write / one-read register FIFO for retire records. The caller guarantees
// pushes never exceed free space measured before any same-cycle pop.
module riscv_retire_fifo
  import riscv_retire_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  rec_t                     data0,
  input  logic                     push1,
  input  rec_t                     data1,
  input  logic                     pop,
  output rec_t                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  rec_t            mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic [AW-1:0]   wr_idx1_s;
  logic            pop_s;

  assign wr_idx1_s = wr_ptr_r + AW'(push0);
  assign pop_s     = pop && (count_r != {(AW+1){1'b0}});

  // Pointer and occupancy update; reset alone empties the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(push0) + AW'(push1);
      rd_ptr_r <= rd_ptr_r + AW'(pop_s);
      count_r  <= count_r + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop_s);
    end
  end

  // Record storage; pipe1 lands behind pipe0 when both are written
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_r[wr_ptr_r] <= data0;
    end
    if (push1) begin
      mem_r[wr_idx1_s] <= data1;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/riscv_retire_trace.sv
// Retirement monitor: counts cycles/retires, logs retire records into a FIFO
// drained over a valid/ready stream, and flags completion or timeout.
module riscv_retire_trace
  import riscv_retire_trace_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_W          = 32,
  parameter int DRAIN_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              pipe0_valid_i,
  input  logic [31:0]       pipe0_pc_i,
  input  logic [31:0]       pipe0_opc_i,
  input  logic [4:0]        pipe0_rd_i,
  input  logic [31:0]       pipe0_result_i,
  input  logic              pipe1_valid_i,
  input  logic [31:0]       pipe1_pc_i,
  input  logic [31:0]       pipe1_opc_i,
  input  logic [4:0]        pipe1_rd_i,
  input  logic [31:0]       pipe1_result_i,
  output logic              trace_valid_o,
  input  logic              trace_ready_i,
  output logic [REC_W-1:0]  trace_data_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic [CNT_W-1:0]  instr_count_o,
  output logic              overflow_o,
  output logic              done_o,
  output logic              timeout_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      DRAIN_LOAD   = 32'(DRAIN_CYCLES - 1);
  localparam logic [AW:0]      DEPTH_V      = (AW+1)'(FIFO_DEPTH);

  state_e            state_r, state_s;
  logic [31:0]       drain_r;
  logic [CNT_W-1:0]  cycle_count_r;
  logic [CNT_W-1:0]  instr_count_r;
  logic              overflow_r, timeout_r, done_r;

  logic              active_s, v0_s, v1_s, trigger_s, timeout_hit_s, to_timeout_s;
  logic              push0_s, push1_s, drop_s, fifo_empty_s;
  logic [AW:0]       fifo_count_s, free_s;
  logic [CNT_W:0]    instr_sum_s;
  rec_t              rec0_s, rec1_s, head_s;

  assign active_s      = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign v0_s          = pipe0_valid_i && active_s;
  assign v1_s          = pipe1_valid_i && active_s;
  assign trigger_s     = (state_r == ST_RUN) &&
                         ((pipe0_valid_i && is_csrrw(pipe0_opc_i)) ||
                          (pipe1_valid_i && is_csrrw(pipe1_opc_i)));
  assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cycle_count_r == TIMEOUT_LAST);
  assign free_s        = DEPTH_V - fifo_count_s;
  assign rec0_s        = pack_rec(1'b0, pipe0_rd_i, pipe0_pc_i, pipe0_opc_i, pipe0_result_i);
  assign rec1_s        = pack_rec(1'b1, pipe1_rd_i, pipe1_pc_i, pipe1_opc_i, pipe1_result_i);
  assign instr_sum_s   = {1'b0, instr_count_r} + (CNT_W+1)'(v0_s) + (CNT_W+1)'(v1_s);

  // Admission: pipe0 takes the first free slot, pipe1 only what remains
  always_comb begin
    push0_s = v0_s && (free_s != {(AW+1){1'b0}});
    if (v0_s) begin
      push1_s = v1_s && (free_s >= (AW+1)'(2));
    end else begin
      push1_s = v1_s && (free_s != {(AW+1){1'b0}});
    end
    drop_s = (v0_s && !push0_s) || (v1_s && !push1_s);
  end

  riscv_retire_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0_s),
    .data0 (rec0_s),
    .push1 (push1_s),
    .data1 (rec1_s),
    .pop   (trace_valid_o && trace_ready_i),
    .head  (head_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  // Next-state decode; trigger takes priority over a coincident timeout
  always_comb begin
    state_s      = state_r;
    to_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable_i) state_s = ST_RUN;
        else          state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (trigger_s) begin
          state_s = ST_DRAIN;
        end else if (timeout_hit_s) begin
          state_s      = ST_DONE;
          to_timeout_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((drain_r == 32'd0) && fifo_empty_s) state_s = ST_DONE;
        else                                    state_s = ST_DRAIN;
      end
      ST_DONE:  state_s = ST_DONE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, drain timer, saturating counters and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      drain_r       <= 32'd0;
      cycle_count_r <= {CNT_W{1'b0}};
      instr_count_r <= {CNT_W{1'b0}};
      overflow_r    <= 1'b0;
      timeout_r     <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == ST_DONE);
      if (trigger_s) begin
        drain_r <= DRAIN_LOAD;
      end else if ((state_r == ST_DRAIN) && (drain_r != 32'd0)) begin
        drain_r <= drain_r - 32'd1;
      end
      if (active_s && (cycle_count_r != CNT_MAX)) begin
        cycle_count_r <= cycle_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (active_s) begin
        instr_count_r <= instr_sum_s[CNT_W] ? CNT_MAX : instr_sum_s[CNT_W-1:0];
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (to_timeout_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign trace_valid_o = !fifo_empty_s;
  assign trace_data_o  = head_s;
  assign cycle_count_o = cycle_count_r;
  assign instr_count_o = instr_count_r;
  assign overflow_o    = overflow_r;
  assign done_o        = done_r;
  assign timeout_o     = timeout_r;

endmodule

// File: tb/tb_riscv_retire_trace.sv
// Directed bench for riscv_retire_trace: expected records go into a queue as
// retires are driven and are compared as the trace stream delivers them.
module tb_riscv_retire_trace;
  import riscv_retire_trace_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] OPC_ADDI = 32'h0010_0093;
  localparam logic [31:0] OPC_CSRW = 32'h3402_9073;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable_i;
  logic         pipe0_valid_i, pipe1_valid_i;
  logic [31:0]  pipe0_pc_i, pipe0_opc_i, pipe0_result_i;
  logic [31:0]  pipe1_pc_i, pipe1_opc_i, pipe1_result_i;
  logic [4:0]   pipe0_rd_i, pipe1_rd_i;
  logic         trace_valid_o, trace_ready_i;
  logic [101:0] trace_data_o;
  logic [31:0]  cycle_count_o, instr_count_o;
  logic         overflow_o, done_o, timeout_o;

  int errors = 0;
  int checks = 0;
  logic [101:0] exp_q [$];

  riscv_retire_trace #(
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(32), .DRAIN_CYCLES(10), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i),
    .pipe0_valid_i(pipe0_valid_i), .pipe0_pc_i(pipe0_pc_i), .pipe0_opc_i(pipe0_opc_i),
    .pipe0_rd_i(pipe0_rd_i), .pipe0_result_i(pipe0_result_i),
    .pipe1_valid_i(pipe1_valid_i), .pipe1_pc_i(pipe1_pc_i), .pipe1_opc_i(pipe1_opc_i),
    .pipe1_rd_i(pipe1_rd_i), .pipe1_result_i(pipe1_result_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i), .trace_data_o(trace_data_o),
    .cycle_count_o(cycle_count_o), .instr_count_o(instr_count_o),
    .overflow_o(overflow_o), .done_o(done_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_pipes();
    pipe0_valid_i = 1'b0; pipe0_pc_i = 32'd0; pipe0_opc_i = 32'd0;
    pipe0_rd_i = 5'd0; pipe0_result_i = 32'd0;
    pipe1_valid_i = 1'b0; pipe1_pc_i = 32'd0; pipe1_opc_i = 32'd0;
    pipe1_rd_i = 5'd0; pipe1_result_i = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0; enable_i = 1'b0; trace_ready_i = 1'b0;
    clear_pipes();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_run();
    enable_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b0;
  endtask

  // One retire cycle; rd and result are derived from the PC. Expected records
  // are queued only while the bench knows the FIFO is not being popped.
  task automatic retire(input logic v0, input logic [31:0] pc0, input logic [31:0] opc0,
                        input logic v1, input logic [31:0] pc1, input logic [31:0] opc1);
    int free;
    free = FIFO_DEPTH - exp_q.size();
    pipe0_valid_i = v0; pipe0_pc_i = pc0; pipe0_opc_i = opc0;
    pipe0_rd_i = pc0[6:2]; pipe0_result_i = ~pc0;
    pipe1_valid_i = v1; pipe1_pc_i = pc1; pipe1_opc_i = opc1;
    pipe1_rd_i = pc1[6:2]; pipe1_result_i = ~pc1;
    if (v0 && free > 0) begin
      exp_q.push_back({1'b0, pc0[6:2], pc0, opc0, ~pc0});
      free--;
    end
    if (v1 && free > 0) begin
      exp_q.push_back({1'b1, pc1[6:2], pc1, opc1, ~pc1});
      free--;
    end
    @(negedge clk);
    clear_pipes();
  endtask

  task automatic drain_check(input string tag, input int budget);
    int waited;
    waited = 0;
    trace_ready_i = 1'b1;
    while (exp_q.size() > 0 && waited < budget) begin
      if (trace_valid_o) check(tag, trace_data_o, exp_q.pop_front());
      @(negedge clk);
      waited++;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_valid"}, trace_valid_o, 1'b0);
    trace_ready_i = 1'b0;
  endtask

  initial begin
    int cyc;

    // 1: reset state, retires in IDLE are ignored
    do_reset();
    check("rst_cycle", cycle_count_o, 32'd0);
    check("rst_instr", instr_count_o, 32'd0);
    check("rst_valid", trace_valid_o, 1'b0);
    check("rst_flags", {done_o, timeout_o, overflow_o}, 3'b000);
    pipe0_valid_i = 1'b1; pipe0_pc_i = 32'h8000_0000; pipe0_opc_i = OPC_ADDI;
    @(negedge clk);
    clear_pipes();
    @(negedge clk);
    check("idle_instr", instr_count_o, 32'd0);
    check("idle_valid", trace_valid_o, 1'b0);

    // 2: dual retire, both records in pipe order
    do_reset();
    start_run();
    trace_ready_i = 1'b1;
    retire(1'b1, 32'h8000_0000, OPC_ADDI, 1'b1, 32'h8000_0004, OPC_ADDI);
    drain_check("t2_rec", 10);
    check("t2_instr", instr_count_o, 32'd2);

    // 3: overflow with consumer stalled
    do_reset();
    start_run();
    for (int i = 0; i < 5; i++) begin
      retire(1'b1, 32'h8000_1000 + 32'(i * 8), OPC_ADDI,
             1'b1, 32'h8000_1004 + 32'(i * 8), OPC_ADDI);
    end
    check("t3_overflow", overflow_o, 1'b1);
    check("t3_instr", instr_count_o, 32'd10);
    check("t3_valid", trace_valid_o, 1'b1);
    drain_check("t3_rec", 20);

    // 4: csrw on pipe1 -> DRAIN, DONE ten cycles after the trigger edge
    do_reset();
    start_run();
    trace_ready_i = 1'b1;
    retire(1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0100, OPC_CSRW);
    cyc = 0;
    while (!done_o && cyc < 30) begin
      if (trace_valid_o && exp_q.size() > 0) check("t4_rec", trace_data_o, exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    check("t4_latency", cyc, 10);
    check("t4_done", done_o, 1'b1);
    check("t4_timeout", timeout_o, 1'b0);
    check("t4_left", exp_q.size(), 0);
    check("t4_instr", instr_count_o, 32'd1);
    check("t4_cycle", cycle_count_o, 32'd11);
    @(negedge clk);
    check("t4_cycle_hold", cycle_count_o, 32'd11);

    // 5: timeout with no trigger
    do_reset();
    start_run();
    cyc = 0;
    while (!done_o && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_latency", cyc, 100);
    check("t5_cycle", cycle_count_o, 32'd100);
    check("t5_flags", {done_o, timeout_o}, 2'b11);

    // 7: trigger in the same cycle as timeout -> trigger wins
    do_reset();
    start_run();
    cyc = 0;
    while (cycle_count_o != 32'd99 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t7_reach99", cycle_count_o, 32'd99);
    trace_ready_i = 1'b1;
    retire(1'b1, 32'h8000_0200, OPC_CSRW, 1'b0, 32'd0, 32'd0);
    check("t7_not_done", {done_o, timeout_o}, 2'b00);
    cyc = 0;
    while (!done_o && cyc < 30) begin
      if (trace_valid_o && exp_q.size() > 0) check("t7_rec", trace_data_o, exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    check("t7_flags", {done_o, timeout_o}, 2'b10);

    // 6: asynchronous reset mid-DRAIN with three queued records
    do_reset();
    start_run();
    retire(1'b1, 32'h8000_0300, OPC_ADDI, 1'b1, 32'h8000_0304, OPC_ADDI);
    retire(1'b1, 32'h8000_0308, OPC_CSRW, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("t6_instr_pre", instr_count_o, 32'd3);
    check("t6_valid_pre", trace_valid_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t6_valid", trace_valid_o, 1'b0);
    check("t6_counts", {cycle_count_o, instr_count_o}, 64'd0);
    check("t6_flags", {done_o, timeout_o, overflow_o}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    pipe0_valid_i = 1'b1; pipe0_pc_i = 32'h8000_0400; pipe0_opc_i = OPC_ADDI;
    repeat (2) @(negedge clk);
    clear_pipes();
    check("t6_idle_instr", instr_count_o, 32'd0);
    check("t6_idle_valid", trace_valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
